// File: rtl/rc4_xor_stream.sv
// Keystream consumer: requests RC4 bytes under credit control, buffers them in a
// small FIFO and XORs them with the plaintext stream, one message per start.
//
// state | meaning
// IDLE  | waiting for start; counters hold last message values
// RUN   | requesting keystream and consuming plaintext
// DRAIN | all plaintext consumed, waiting for last ciphertext to leave
// DONE  | one-cycle message-complete pulse
module rc4_xor_stream #(
  parameter int KS_DEPTH = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] msg_len_i,
  output logic             ks_req_o,
  input  logic             ks_valid_i,
  input  logic [7:0]       ks_byte_i,
  input  logic             pt_valid_i,
  input  logic [7:0]       pt_data_i,
  output logic             pt_ready_o,
  output logic             ct_valid_o,
  output logic [7:0]       ct_data_o,
  input  logic             ct_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] byte_cnt_o,
  output logic             ks_err_o
);

  localparam int PW = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
  localparam int FW = PW + 1;
  localparam int CW = PW + 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0] pt_cnt_q, pt_cnt_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [FW-1:0]    out_cnt_q, out_cnt_d;
  logic [FW-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             ks_req_q, ks_req_d;
  logic             ct_valid_q, ct_valid_d;
  logic             ks_err_q, ks_err_d;
  logic [7:0]       ct_data_q, ct_data_d;
  logic [7:0]       fifo_mem_q [KS_DEPTH];

  logic             push;
  logic             pop;
  logic             ct_hs;
  logic [CNT_W:0]   req_sum;
  logic [CW-1:0]    credit;

  // A byte is only accepted against an outstanding request; anything else is dropped.
  assign push    = ks_valid_i && (out_cnt_q != '0);
  assign pt_ready_o = (state_q == S_RUN) && (fifo_cnt_q != '0) && (pt_cnt_q < len_q)
                      && (!ct_valid_q || ct_ready_i);
  assign pop     = pt_valid_i && pt_ready_o;
  assign ct_hs   = ct_valid_q && ct_ready_i;
  assign req_sum = {1'b0, req_cnt_q} + {{CNT_W{1'b0}}, ks_req_q};
  assign credit  = CW'(fifo_cnt_q) + CW'(out_cnt_q) + CW'(ks_req_q);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    req_cnt_d  = req_cnt_q + CNT_W'(ks_req_q);
    out_cnt_d  = out_cnt_q + FW'(ks_req_q) - FW'(push);
    fifo_cnt_d = fifo_cnt_q + FW'(push) - FW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    pt_cnt_d   = pt_cnt_q + CNT_W'(pop);
    byte_cnt_d = byte_cnt_q + CNT_W'(ct_hs);
    ks_err_d   = ks_err_q | (ks_valid_i && (out_cnt_q == '0));
    ct_valid_d = ct_valid_q & ~ct_ready_i;
    ct_data_d  = ct_data_q;
    if (pop) begin
      ct_valid_d = 1'b1;
      ct_data_d  = pt_data_i ^ fifo_mem_q[rd_ptr_q];
    end
    // The in-flight request register counts against both length and credit.
    ks_req_d = (state_q == S_RUN) && (req_sum < {1'b0, len_q})
               && (credit < CW'(KS_DEPTH));

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d      = msg_len_i;
          req_cnt_d  = '0;
          out_cnt_d  = '0;
          fifo_cnt_d = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          pt_cnt_d   = '0;
          byte_cnt_d = '0;
          ks_err_d   = 1'b0;
          if (msg_len_i == '0) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_RUN;
            ks_req_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (pt_cnt_d == len_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((byte_cnt_d == len_q) && !ct_valid_d) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      req_cnt_q  <= '0;
      out_cnt_q  <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pt_cnt_q   <= '0;
      byte_cnt_q <= '0;
      ks_req_q   <= 1'b0;
      ct_valid_q <= 1'b0;
      ct_data_q  <= 8'h00;
      ks_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      req_cnt_q  <= req_cnt_d;
      out_cnt_q  <= out_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pt_cnt_q   <= pt_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      ks_req_q   <= ks_req_d;
      ct_valid_q <= ct_valid_d;
      ct_data_q  <= ct_data_d;
      ks_err_q   <= ks_err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem_q[wr_ptr_q] <= ks_byte_i;
  end

  assign ks_req_o   = ks_req_q;
  assign ct_valid_o = ct_valid_q;
  assign ct_data_o  = ct_data_q;
  assign busy_o     = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done_o     = (state_q == S_DONE);
  assign byte_cnt_o = byte_cnt_q;
  assign ks_err_o   = ks_err_q;

endmodule

// File: tb/tb_rc4_xor_stream.sv
// Scoreboard bench for rc4_xor_stream: keystream stub with programmable latency,
// expected ciphertext = i-th plaintext byte XOR i-th keystream byte.
module tb_rc4_xor_stream;
  localparam int KS_DEPTH = 4;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] msg_len = '0;
  logic             ks_valid = 1'b0;
  logic [7:0]       ks_byte = 8'h00;
  logic             pt_valid = 1'b0;
  logic [7:0]       pt_data = 8'h00;
  logic             ct_ready = 1'b1;
  logic             ks_req_o, pt_ready_o, ct_valid_o, busy_o, done_o, ks_err_o;
  logic [7:0]       ct_data_o;
  logic [CNT_W-1:0] byte_cnt_o;

  rc4_xor_stream #(.KS_DEPTH(KS_DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .msg_len_i(msg_len),
    .ks_req_o(ks_req_o), .ks_valid_i(ks_valid), .ks_byte_i(ks_byte),
    .pt_valid_i(pt_valid), .pt_data_i(pt_data), .pt_ready_o(pt_ready_o),
    .ct_valid_o(ct_valid_o), .ct_data_o(ct_data_o), .ct_ready_i(ct_ready),
    .busy_o(busy_o), .done_o(done_o), .byte_cnt_o(byte_cnt_o), .ks_err_o(ks_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic [7:0] expq[$];
  logic [7:0] ks_src[$];
  int         pend_due[$];
  logic [7:0] pend_byte[$];
  int         lat = 1;
  int         stall_pct = 0;
  bit         inject_req = 1'b0;
  int         reqs = 0, pops = 0, done_cnt = 0, start_cyc = 0, last_ct_cyc = 0, cur_len = 0;
  bit         busy_seen = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Keystream generator stub: each request is answered lat cycles later.
  initial forever begin
    @(posedge clk); #1;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      ks_valid = 1'b1;
      ks_byte  = pend_byte.pop_front();
      void'(pend_due.pop_front());
    end else if (inject_req && pend_due.size() == 0) begin
      ks_valid   = 1'b1;
      ks_byte    = 8'($urandom);
      inject_req = 1'b0;
    end else begin
      ks_valid = 1'b0;
    end
    @(negedge clk);
    if (ks_req_o) begin
      pend_due.push_back(cyc + lat);
      if (ks_src.size() > 0) pend_byte.push_back(ks_src.pop_front());
      else pend_byte.push_back(8'h00);
    end
  end

  initial forever begin
    @(posedge clk); #1;
    ct_ready = ($urandom_range(99) >= stall_pct);
  end

  // Monitor: scoreboard pops, stall/credit/done checks.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("ct_valid_hold", int'(ct_valid_o), 1);
        chk("ct_hold", int'(ct_data_o), int'(prev_data));
      end
      if (busy_o) begin
        busy_seen = 1'b1;
        chk("credit_le_depth", int'((reqs + int'(ks_req_o) - pops) <= KS_DEPTH), 1);
      end
      if (ks_req_o) reqs++;
      if (pt_valid && pt_ready_o) pops++;
      if (ct_valid_o && !ct_ready) chk("pt_ready_blk", int'(pt_ready_o), 0);
      if (ct_valid_o && ct_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ct_extra actual=%0h expected=none", ct_data_o);
        end else begin
          chk("ct_byte", int'(ct_data_o), int'(expq.pop_front()));
        end
        last_ct_cyc = cyc;
      end
      if (done_o) begin
        done_cnt++;
        chk("busy_at_done", int'(busy_o), 0);
        chk("byte_cnt", int'(byte_cnt_o), cur_len);
        chk("done_timing", cyc, (cur_len == 0) ? start_cyc + 1 : last_ct_cyc + 1);
      end
      prev_stall = ct_valid_o && !ct_ready;
      prev_data  = ct_data_o;
    end
  end

  task automatic run_msg(input int len, input int l, input int stall, input int gap,
                         input int hold0, input bit golden, input bit inject);
    logic [7:0] pt_b[$];
    logic [7:0] ks_b[$];
    string      gs = "Plaintext";
    logic [7:0] gks[9] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7};
    logic [7:0] gct[9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    bit         ok;
    int         n;
    ks_src.delete();
    for (int i = 0; i < len; i++) begin
      if (golden) begin
        pt_b.push_back(gs[i]);
        ks_b.push_back(gks[i]);
      end else begin
        pt_b.push_back(8'($urandom));
        ks_b.push_back(8'($urandom));
      end
      ks_src.push_back(ks_b[i]);
    end
    lat       = l;
    stall_pct = stall;
    @(posedge clk); #1;
    start     = 1'b1;
    msg_len   = CNT_W'(len);
    cur_len   = len;
    start_cyc = cyc;
    reqs      = 0;
    pops      = 0;
    done_cnt  = 0;
    busy_seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("ks_err_clr", int'(ks_err_o), 0);
    chk("first_req", int'(ks_req_o), int'(len != 0));
    chk("busy_start", int'(busy_o), int'(len != 0));
    if (inject) inject_req = 1'b1;
    repeat (hold0) @(posedge clk);
    ok = 1'b1;
    for (int i = 0; i < len && ok; i++) begin
      while ($urandom_range(99) < gap) begin
        @(posedge clk); #1;
        pt_valid = 1'b0;
      end
      @(posedge clk); #1;
      pt_valid = 1'b1;
      pt_data  = pt_b[i];
      expq.push_back(golden ? gct[i] : (pt_b[i] ^ ks_b[i]));
      n = 0;
      forever begin
        @(negedge clk);
        if (pt_ready_o) break;
        n++;
        if (n > 500) begin
          checks++;
          errors++;
          $display("FAIL pt_timeout actual=%0d expected=%0d", i, len);
          ok = 1'b0;
          break;
        end
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    pt_valid = 1'b0;
    n = 0;
    while (done_cnt == 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("done_seen", int'(done_cnt != 0), 1);
    repeat (3) @(posedge clk);
    chk("done_once", done_cnt, 1);
    chk("ks_req_cnt", reqs, len);
    chk("sb_empty", expq.size(), 0);
    chk("ks_err", int'(ks_err_o), int'(inject));
    if (len == 0) chk("busy_zero", int'(busy_seen), 0);
    expq.delete();
  endtask

  task automatic check_reset_outputs();
    chk("rst_ks_req", int'(ks_req_o), 0);
    chk("rst_pt_ready", int'(pt_ready_o), 0);
    chk("rst_ct_valid", int'(ct_valid_o), 0);
    chk("rst_ct_data", int'(ct_data_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_byte_cnt", int'(byte_cnt_o), 0);
    chk("rst_ks_err", int'(ks_err_o), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();

    run_msg(9, 1, 0, 0, 0, 1'b1, 1'b0);
    run_msg(20, 5, 0, 0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      run_msg($urandom_range(40, 10), $urandom_range(3, 1), 50, 30, 0, 1'b0, 1'b0);
    run_msg(0, 1, 0, 0, 0, 1'b0, 1'b0);

    // Reset in the middle of a message with generator bytes still in flight.
    ks_src.delete();
    for (int i = 0; i < 10; i++) ks_src.push_back(8'($urandom));
    lat       = 5;
    stall_pct = 0;
    @(posedge clk); #1;
    start     = 1'b1;
    msg_len   = CNT_W'(10);
    cur_len   = 10;
    start_cyc = cyc;
    reqs      = 0;
    pops      = 0;
    done_cnt  = 0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    expq.delete();
    n = 0;
    while (pend_due.size() > 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("ks_err_late", int'(ks_err_o), 1);

    run_msg(8, 2, 30, 20, 0, 1'b0, 1'b0);
    run_msg(12, 1, 0, 0, 12, 1'b0, 1'b1);
    run_msg(15, 1, 0, 0, 0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=%0d expected=finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
